open_drain_bank: RTL and testbench
==================================

// Module: open_drain_bank
// PURPOSE
//  Multi-channel open-drain pad bank: successor to the two-pin open-drain bring-up logic, for the I2C SDA/SCL pads.
//  Per channel: drives the pad low or releases it (Z), synchronises and glitch-filters the line, flags edges, counts
//  falling edges, detects a line held low by another agent, and runs a self-test pulse train for board-level checks.
// PARAMETERS
//  CHANNELS       2         number of open-drain pads
//  SYNC_STAGES    2         synchroniser flops per pad (>=2)
//  FILTER_CYCLES  4         consecutive differing samples needed to accept a level change (>=1)
//  TICK_INTERVAL  27000000  pulse period in clk_i cycles (even, >=4); release first half, drive low second half
//  PULSE_W        4         width of requested pulse count
//  COUNT_W        8         width of each falling-edge counter
//  STUCK_CYCLES   1024      cycles line_o low while not self-driven before stuck_low_o; must be > SYNC_STAGES+FILTER_CYCLES
// PORTS
//  clk_i          in     1                 system clock
//  rst_ni         in     1                 asynchronous active-low reset
//  drive_low_i    in     CHANNELS          1 = pull pad low, 0 = release
//  pulse_start_i  in     CHANNELS          1-cycle request to start a pulse train
//  pulse_num_i    in     CHANNELS*PULSE_W  pulses requested, sampled with pulse_start_i
//  cnt_clr_i      in     CHANNELS          clear falling-edge counter
//  pin_io         inout  CHANNELS          open-drain pads (external pull-up)
//  line_o         out    CHANNELS          filtered line level
//  fall_o         out    CHANNELS          1-cycle pulse on filtered 1->0
//  rise_o         out    CHANNELS          1-cycle pulse on filtered 0->1
//  fall_count_o   out    CHANNELS*COUNT_W  saturating falling-edge count
//  pulse_busy_o   out    CHANNELS          pulse train in progress
//  pulse_done_o   out    CHANNELS          1-cycle pulse when a train completes
//  stuck_low_o    out    CHANNELS          line held low by another agent
// BEHAVIOUR
//  - Reset (async, any time incl. mid-train): pads released (Z) immediately; sync flops and line_o = 1; fall_o, rise_o,
//    pulse_busy_o, pulse_done_o, stuck_low_o = 0; fall_count_o = 0; pulse FSM -> IDLE; tick/pulse counters = 0.
//  - Pad: pin_io[i] = (drive_low_i[i] | pulse_drv[i]) ? 1'b0 : 1'bz. Never drives 1.
//  - Filter: counter increments while synced sample != line_o, zeroes on agreement. At FILTER_CYCLES, line_o takes the
//    sample. Pad edge -> line_o change latency = SYNC_STAGES+FILTER_CYCLES cycles. Shorter glitches are discarded.
//  - fall_o/rise_o: registered, asserted in the first cycle line_o shows the new value.
//  - fall_count: +1 per fall_o, saturates at 2^COUNT_W-1. cnt_clr_i alone -> 0; cnt_clr_i with fall_o the same cycle -> 1.
//  - Pulse FSM per channel: IDLE, REL, LOW.
//    IDLE: pulse_start_i with num>0 -> latch num, tick=0, done_cnt=0, busy=1, go REL.
//          num==0 -> pulse_done_o next cycle, pad never driven, busy stays 0.
//    REL:  pulse_drv=0 for TICK_INTERVAL/2 cycles, then LOW.
//    LOW:  pulse_drv=1 for TICK_INTERVAL/2 cycles; then done_cnt+1. If done_cnt==num: IDLE, busy=0, pulse_done_o=1 for
//          1 cycle, pad released that same edge. Otherwise go REL.
//    pulse_start_i while busy is ignored. drive_low_i ORs with pulse_drv and does not affect the FSM.
//  - Stuck: counter runs while line_o==0 and the channel is not self-driving (drive_low_i|pulse_drv==0); zeroes otherwise.
//    At STUCK_CYCLES, stuck_low_o=1 and stays set until line_o==1 (cleared on that cycle). Counter saturates.
//    Cycles in which the channel self-drives reset the count.
// STRUCTURE
//  - Package od_pkg: FSM state localparams (OD_IDLE/OD_REL/OD_LOW, 2-bit) and a clog2-style width helper function.
//  - Sub-module open_drain_channel: one pad with sync, filter, edge flags, counter, pulse FSM and stuck detection.
//    open_drain_bank is a generate loop over CHANNELS plus bus slicing.
// TESTING (CHANNELS=2, SYNC=2, FILTER=3, TICK_INTERVAL=20, STUCK=16, COUNT_W=8; pins tied to one net with pull-up)
//  1. ch0 start num=5 -> net low 10 of every 20 cycles, 5 times; ch0 and ch1 fall_count=5; ch0 pulse_done 1 cycle
//     after ~100 cycles; ch1 stuck_low_o never set.
//  2. Force net low 2 cycles -> no line_o change, no fall_o. Force 3 cycles -> single fall_o 5 cycles after the edge.
//  3. Force net low 40 cycles, no drives -> stuck_low_o=1 on both channels 16 cycles after line_o falls; release -> 0.
//  4. COUNT_W=3, 9 pulses -> fall_count=7. cnt_clr_i with fall_o the same cycle -> count=1.
//  5. num=0 -> pulse_done_o next cycle, net never low. Start again while busy -> ignored, original train completes.
//  6. rst_ni low mid-LOW phase -> pad Z same cycle, busy=0, counts=0, line_o=1. After release, new train runs normally.

Source files
------------

// File: rtl/od_pkg.sv
// Shared types and helpers for the open-drain pad bank.
// Pulse-train FSM encoding and a counter width helper.
package od_pkg;

    typedef enum logic [1:0] {
        OD_IDLE = 2'd0,
        OD_REL  = 2'd1,
        OD_LOW  = 2'd2
    } od_state_e;

    // Bits needed to hold any value in 0..n.
    function automatic int od_width(input int n);
        int w;
        w = 1;
        while ((64'd1 << w) <= 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/open_drain_bank_if.sv
// Control and status bundle of the open-drain pad bank.
// The master side drives requests; the slave side is the bank.
interface open_drain_bank_if #(
    parameter int CHANNELS = 2,
    parameter int PULSE_W  = 4,
    parameter int COUNT_W  = 8
);

    logic [CHANNELS-1:0]         drive_low_i;
    logic [CHANNELS-1:0]         pulse_start_i;
    logic [CHANNELS*PULSE_W-1:0] pulse_num_i;
    logic [CHANNELS-1:0]         cnt_clr_i;
    logic [CHANNELS-1:0]         line_o;
    logic [CHANNELS-1:0]         fall_o;
    logic [CHANNELS-1:0]         rise_o;
    logic [CHANNELS*COUNT_W-1:0] fall_count_o;
    logic [CHANNELS-1:0]         pulse_busy_o;
    logic [CHANNELS-1:0]         pulse_done_o;
    logic [CHANNELS-1:0]         stuck_low_o;

    modport master (
        output drive_low_i,
        output pulse_start_i,
        output pulse_num_i,
        output cnt_clr_i,
        input  line_o,
        input  fall_o,
        input  rise_o,
        input  fall_count_o,
        input  pulse_busy_o,
        input  pulse_done_o,
        input  stuck_low_o
    );

    modport slave (
        input  drive_low_i,
        input  pulse_start_i,
        input  pulse_num_i,
        input  cnt_clr_i,
        output line_o,
        output fall_o,
        output rise_o,
        output fall_count_o,
        output pulse_busy_o,
        output pulse_done_o,
        output stuck_low_o
    );

endinterface

// File: rtl/open_drain_channel.sv
// One open-drain pad: sync, glitch filter, edge flags, fall counter,
// pulse-train generator and stuck-low detection.
module open_drain_channel
    import od_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int TICK_INTERVAL = 27000000,
    parameter int PULSE_W       = 4,
    parameter int COUNT_W       = 8,
    parameter int STUCK_CYCLES  = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pad_i,
    input  logic               drive_low_i,
    input  logic               pulse_start_i,
    input  logic [PULSE_W-1:0] pulse_num_i,
    input  logic               cnt_clr_i,
    output logic               line_o,
    output logic               fall_o,
    output logic               rise_o,
    output logic [COUNT_W-1:0] fall_count_o,
    output logic               pulse_busy_o,
    output logic               pulse_done_o,
    output logic               stuck_low_o,
    output logic               pulse_drv_o
);

    localparam int HALF = TICK_INTERVAL / 2;
    localparam int FW   = od_width(FILTER_CYCLES);
    localparam int TW   = od_width(HALF);
    localparam int SW   = od_width(STUCK_CYCLES);

    localparam logic [FW-1:0] FLT_LAST   = FW'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(HALF - 1);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYCLES);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic [FW-1:0]          flt_q;
    logic                   line_q;
    logic                   differ;
    logic                   accept;
    logic                   line_d;
    logic                   fall_q;
    logic                   rise_q;
    logic [COUNT_W-1:0]     cnt_q;

    od_state_e              state_q;
    logic [TW-1:0]          tick_q;
    logic                   tick_end;
    logic [PULSE_W-1:0]     num_q;
    logic [PULSE_W-1:0]     done_cnt_q;
    logic [PULSE_W-1:0]     done_nxt;
    logic                   busy_q;
    logic                   done_q;
    logic                   drv_q;

    logic                   self_drv;
    logic                   stuck_run;
    logic [SW-1:0]          stk_q;
    logic                   stuck_q;

    assign sample = sync_q[SYNC_STAGES-1];
    assign differ = sample ^ line_q;
    assign accept = differ && (flt_q == FLT_LAST);
    assign line_d = accept ? sample : line_q;

    // Pad synchroniser; idles high like the pulled-up line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    // Glitch filter and edge flags; a new level needs FILTER_CYCLES
    // consecutive disagreeing samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flt_q  <= '0;
            line_q <= 1'b1;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            flt_q  <= (differ && !accept) ? flt_q + 1'b1 : '0;
            line_q <= line_d;
            fall_q <= accept & ~sample;
            rise_q <= accept & sample;
        end
    end

    // Saturating fall counter; a clear coinciding with a fall keeps that fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= COUNT_W'(fall_q);
        end else if (fall_q && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_end = (tick_q == TICK_LAST);
    assign done_nxt = done_cnt_q + 1'b1;

    // Pulse train: release half a period, pull low half a period, repeat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= OD_IDLE;
            tick_q     <= '0;
            num_q      <= '0;
            done_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drv_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                OD_IDLE: begin
                    if (pulse_start_i) begin
                        if (pulse_num_i != '0) begin
                            num_q      <= pulse_num_i;
                            tick_q     <= '0;
                            done_cnt_q <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= OD_REL;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                OD_REL: begin
                    if (tick_end) begin
                        tick_q  <= '0;
                        drv_q   <= 1'b1;
                        state_q <= OD_LOW;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                OD_LOW: begin
                    if (tick_end) begin
                        tick_q     <= '0;
                        drv_q      <= 1'b0;
                        done_cnt_q <= done_nxt;
                        if (done_nxt == num_q) begin
                            state_q <= OD_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= OD_REL;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= OD_IDLE;
                    busy_q  <= 1'b0;
                    drv_q   <= 1'b0;
                end
            endcase
        end
    end

    assign self_drv  = drive_low_i | drv_q;
    assign stuck_run = ~line_q & ~self_drv;

    // Stuck-low detect: time low-while-released; flag drops as the line rises.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stk_q   <= '0;
            stuck_q <= 1'b0;
        end else begin
            if (!stuck_run) begin
                stk_q <= '0;
            end else if (stk_q != STUCK_MAX) begin
                stk_q <= stk_q + 1'b1;
            end
            if (line_d) begin
                stuck_q <= 1'b0;
            end else if (stuck_run && (stk_q == STUCK_LAST)) begin
                stuck_q <= 1'b1;
            end
        end
    end

    assign line_o       = line_q;
    assign fall_o       = fall_q;
    assign rise_o       = rise_q;
    assign fall_count_o = cnt_q;
    assign pulse_busy_o = busy_q;
    assign pulse_done_o = done_q;
    assign stuck_low_o  = stuck_q;
    assign pulse_drv_o  = drv_q;

endmodule

// File: rtl/open_drain_bank.sv
// Bank of open-drain pads for the I2C SDA/SCL lines.
// One channel per pad; pads only ever pull low or float.
module open_drain_bank
    import od_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int TICK_INTERVAL = 27000000,
    parameter int PULSE_W       = 4,
    parameter int COUNT_W       = 8,
    parameter int STUCK_CYCLES  = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    inout  wire  [CHANNELS-1:0] pin_io,
    open_drain_bank_if.slave    bus
);

    logic [CHANNELS-1:0] pulse_drv;
    logic [CHANNELS-1:0] pad_drv;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        open_drain_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .TICK_INTERVAL (TICK_INTERVAL),
            .PULSE_W       (PULSE_W),
            .COUNT_W       (COUNT_W),
            .STUCK_CYCLES  (STUCK_CYCLES)
        ) u_ch (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .pad_i         (pin_io[i]),
            .drive_low_i   (bus.drive_low_i[i]),
            .pulse_start_i (bus.pulse_start_i[i]),
            .pulse_num_i   (bus.pulse_num_i[i*PULSE_W +: PULSE_W]),
            .cnt_clr_i     (bus.cnt_clr_i[i]),
            .line_o        (bus.line_o[i]),
            .fall_o        (bus.fall_o[i]),
            .rise_o        (bus.rise_o[i]),
            .fall_count_o  (bus.fall_count_o[i*COUNT_W +: COUNT_W]),
            .pulse_busy_o  (bus.pulse_busy_o[i]),
            .pulse_done_o  (bus.pulse_done_o[i]),
            .stuck_low_o   (bus.stuck_low_o[i]),
            .pulse_drv_o   (pulse_drv[i])
        );

        assign pad_drv[i] = bus.drive_low_i[i] | pulse_drv[i];
        assign pin_io[i]  = pad_drv[i] ? 1'b0 : 1'bz;
    end

endmodule

// File: tb/tb_open_drain_bank.sv
// Directed bench for open_drain_bank: both pads share one pulled-up net.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_open_drain_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tb_low_a = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   exp_fc = 0;

    always #5 clk = ~clk;

    open_drain_bank_if #(.CHANNELS(2), .PULSE_W(4), .COUNT_W(8)) bus_a ();
    open_drain_bank_if #(.CHANNELS(2), .PULSE_W(4), .COUNT_W(3)) bus_b ();

    wire [1:0] pins_a;
    wire [1:0] pins_b;
    wire       low_a;
    wire       low_b;

    // Wired-AND net: any pad pulling low (or the bench) pulls both pins.
    assign low_a = tb_low_a | (|u_a.pad_drv);
    assign low_b = |u_b.pad_drv;
    assign pins_a[0] = low_a ? 1'b0 : 1'bz;
    assign pins_a[1] = low_a ? 1'b0 : 1'bz;
    assign pins_b[0] = low_b ? 1'b0 : 1'bz;
    assign pins_b[1] = low_b ? 1'b0 : 1'bz;
    pullup pu_a0 (pins_a[0]);
    pullup pu_a1 (pins_a[1]);
    pullup pu_b0 (pins_b[0]);
    pullup pu_b1 (pins_b[1]);

    open_drain_bank #(
        .CHANNELS(2), .SYNC_STAGES(2), .FILTER_CYCLES(3),
        .TICK_INTERVAL(20), .PULSE_W(4), .COUNT_W(8), .STUCK_CYCLES(16)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_n), .pin_io(pins_a), .bus(bus_a)
    );

    open_drain_bank #(
        .CHANNELS(2), .SYNC_STAGES(2), .FILTER_CYCLES(3),
        .TICK_INTERVAL(20), .PULSE_W(4), .COUNT_W(3), .STUCK_CYCLES(16)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n), .pin_io(pins_b), .bus(bus_b)
    );

    typedef struct {
        int src;      // 0 bench pulls net, 1 ch0 drive_low, 2 ch1 drive_low
        int len;      // cycles held low
        int exp_fall; // falls expected on each channel
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_low(input int src, input logic v);
        if (src == 0) tb_low_a = v;
        else if (src == 1) bus_a.drive_low_i[0] = v;
        else bus_a.drive_low_i[1] = v;
    endtask

    task automatic run_table();
        vec_t vt[6];
        vt[0] = '{0, 1, 0};
        vt[1] = '{0, 2, 0};
        vt[2] = '{0, 3, 1};
        vt[3] = '{1, 3, 1};
        vt[4] = '{2, 6, 1};
        vt[5] = '{1, 2, 0};
        for (int v = 0; v < 6; v++) begin
            int nf0 = 0;
            int nf1 = 0;
            int nr0 = 0;
            int at_f = -1;
            int at_r = -1;
            set_low(vt[v].src, 1'b1);
            for (int n = 1; n <= vt[v].len + 10; n++) begin
                @(negedge clk);
                if (n == vt[v].len) set_low(vt[v].src, 1'b0);
                if (bus_a.fall_o[0]) begin nf0++; at_f = n; end
                if (bus_a.fall_o[1]) nf1++;
                if (bus_a.rise_o[0]) begin nr0++; at_r = n; end
            end
            chk($sformatf("vec%0d_fall0", v), nf0, vt[v].exp_fall);
            chk($sformatf("vec%0d_fall1", v), nf1, vt[v].exp_fall);
            chk($sformatf("vec%0d_rise0", v), nr0, vt[v].exp_fall);
            if (vt[v].exp_fall != 0) begin
                chk($sformatf("vec%0d_fall_lat", v), at_f, 5);
                chk($sformatf("vec%0d_rise_lat", v), at_r, vt[v].len + 5);
            end
            chk($sformatf("vec%0d_line", v), bus_a.line_o, 3);
            exp_fc += vt[v].exp_fall;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        bus_a.drive_low_i = '0;
        bus_a.pulse_start_i = '0;
        bus_a.pulse_num_i = '0;
        bus_a.cnt_clr_i = '0;
        bus_b.drive_low_i = '0;
        bus_b.pulse_start_i = '0;
        bus_b.pulse_num_i = '0;
        bus_b.cnt_clr_i = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_line", bus_a.line_o, 3);
        chk("rst_fall", bus_a.fall_o, 0);
        chk("rst_rise", bus_a.rise_o, 0);
        chk("rst_busy", bus_a.pulse_busy_o, 0);
        chk("rst_done", bus_a.pulse_done_o, 0);
        chk("rst_stuck", bus_a.stuck_low_o, 0);
        chk("rst_count", bus_a.fall_count_o, 0);
        chk("rst_pins", pins_a, 3);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Glitch widths and drive sources
        run_table();
        chk("tbl_count0", bus_a.fall_count_o[7:0], exp_fc);
        chk("tbl_count1", bus_a.fall_count_o[15:8], exp_fc);
        bus_a.cnt_clr_i = 2'b11;
        @(negedge clk);
        bus_a.cnt_clr_i = '0;
        chk("clr_alone", bus_a.fall_count_o, 0);
        exp_fc = 0;

        // Five-pulse train on ch0
        begin
            int netlow = 0, nf0 = 0, nf1 = 0, nd = 0, nd1 = 0;
            int at_d = -1, first_low = -1, busy_n = 0, stk = 0;
            bus_a.pulse_num_i = 8'h05;
            bus_a.pulse_start_i = 2'b01;
            for (int n = 1; n <= 110; n++) begin
                @(negedge clk);
                if (n == 1) bus_a.pulse_start_i = '0;
                if (!pins_a[1]) begin
                    netlow++;
                    if (first_low < 0) first_low = n;
                end
                if (bus_a.fall_o[0]) nf0++;
                if (bus_a.fall_o[1]) nf1++;
                if (bus_a.pulse_done_o[0]) begin nd++; at_d = n; end
                if (bus_a.pulse_done_o[1]) nd1++;
                if (bus_a.pulse_busy_o[0]) busy_n++;
                if (bus_a.stuck_low_o[1]) stk++;
            end
            chk("t1_netlow", netlow, 50);
            chk("t1_first_low", first_low, 11);
            chk("t1_fall0", nf0, 5);
            chk("t1_fall1", nf1, 5);
            chk("t1_done_n", nd, 1);
            chk("t1_done_at", at_d, 101);
            chk("t1_done1", nd1, 0);
            chk("t1_busy_cyc", busy_n, 100);
            chk("t1_stuck1", stk, 0);
            exp_fc = 5;
            chk("t1_count0", bus_a.fall_count_o[7:0], exp_fc);
            chk("t1_count1", bus_a.fall_count_o[15:8], exp_fc);
        end
        repeat (5) @(negedge clk);

        // Net held low by someone else
        tb_low_a = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == 40) tb_low_a = 1'b0;
            chk($sformatf("t3_line0_n%0d", n), bus_a.line_o[0],
                (n >= 5 && n < 45) ? 0 : 1);
            chk($sformatf("t3_stuck0_n%0d", n), bus_a.stuck_low_o[0],
                (n >= 21 && n < 45) ? 1 : 0);
            chk($sformatf("t3_stuck1_n%0d", n), bus_a.stuck_low_o[1],
                (n >= 21 && n < 45) ? 1 : 0);
        end
        exp_fc += 1;
        repeat (5) @(negedge clk);

        // Zero-length request, then a start while busy
        begin
            int nd = 0, at_d = -1, busy_n = 0, netlow = 0;
            bus_a.pulse_num_i = 8'h00;
            bus_a.pulse_start_i = 2'b01;
            for (int n = 1; n <= 30; n++) begin
                @(negedge clk);
                if (n == 1) bus_a.pulse_start_i = '0;
                if (bus_a.pulse_done_o[0]) begin nd++; at_d = n; end
                if (bus_a.pulse_busy_o[0]) busy_n++;
                if (!pins_a[0]) netlow++;
            end
            chk("t5_zero_done_n", nd, 1);
            chk("t5_zero_done_at", at_d, 1);
            chk("t5_zero_busy", busy_n, 0);
            chk("t5_zero_netlow", netlow, 0);
        end
        begin
            int nd = 0, at_d = -1, busy_n = 0, netlow = 0, nf = 0;
            bus_a.pulse_num_i = 8'h02;
            bus_a.pulse_start_i = 2'b01;
            for (int n = 1; n <= 60; n++) begin
                @(negedge clk);
                if (n == 1) bus_a.pulse_start_i = '0;
                if (n == 30) begin
                    bus_a.pulse_num_i = 8'h03;
                    bus_a.pulse_start_i = 2'b01;
                end
                if (n == 31) bus_a.pulse_start_i = '0;
                if (bus_a.pulse_done_o[0]) begin nd++; at_d = n; end
                if (bus_a.pulse_busy_o[0]) busy_n++;
                if (!pins_a[0]) netlow++;
                if (bus_a.fall_o[0]) nf++;
            end
            chk("t5_busy_done_n", nd, 1);
            chk("t5_busy_done_at", at_d, 41);
            chk("t5_busy_cyc", busy_n, 40);
            chk("t5_busy_netlow", netlow, 20);
            chk("t5_busy_falls", nf, 2);
            exp_fc += 2;
            chk("t5_count0", bus_a.fall_count_o[7:0], exp_fc);
            chk("t5_count1", bus_a.fall_count_o[15:8], exp_fc);
        end

        // Narrow counter saturation and clear-with-fall on the second bank
        begin
            int nf = 0, at_d = -1, seen = 0;
            bus_b.pulse_num_i = 8'h09;
            bus_b.pulse_start_i = 2'b01;
            for (int n = 1; n <= 190; n++) begin
                @(negedge clk);
                if (n == 1) bus_b.pulse_start_i = '0;
                if (bus_b.fall_o[1]) nf++;
                if (bus_b.pulse_done_o[0]) at_d = n;
            end
            chk("t4_falls", nf, 9);
            chk("t4_done_at", at_d, 181);
            chk("t4_sat0", bus_b.fall_count_o[2:0], 7);
            chk("t4_sat1", bus_b.fall_count_o[5:3], 7);
            bus_b.cnt_clr_i = 2'b11;
            @(negedge clk);
            bus_b.cnt_clr_i = '0;
            chk("t4_clr_alone", bus_b.fall_count_o, 0);
            bus_b.pulse_num_i = 8'h01;
            bus_b.pulse_start_i = 2'b01;
            for (int n = 1; n <= 40 && seen == 0; n++) begin
                @(negedge clk);
                if (n == 1) bus_b.pulse_start_i = '0;
                if (bus_b.fall_o[0]) begin
                    seen = 1;
                    bus_b.cnt_clr_i = 2'b11;
                    @(negedge clk);
                    bus_b.cnt_clr_i = '0;
                    chk("t4_clr_fall0", bus_b.fall_count_o[2:0], 1);
                    chk("t4_clr_fall1", bus_b.fall_count_o[5:3], 1);
                end
            end
            chk("t4_clr_fall_seen", seen, 1);
            repeat (30) @(negedge clk);
        end

        // Asynchronous reset in the middle of a low phase
        begin
            int nd = 0, at_d = -1, nf = 0;
            bus_a.pulse_num_i = 8'h03;
            bus_a.pulse_start_i = 2'b01;
            for (int n = 1; n <= 15; n++) begin
                @(negedge clk);
                if (n == 1) bus_a.pulse_start_i = '0;
            end
            chk("t6_pre_low", pins_a[0], 0);
            chk("t6_pre_busy", bus_a.pulse_busy_o[0], 1);
            rst_n = 1'b0;
            #1;
            chk("t6_pin0", pins_a[0], 1);
            chk("t6_pin1", pins_a[1], 1);
            chk("t6_busy", bus_a.pulse_busy_o, 0);
            chk("t6_line", bus_a.line_o, 3);
            chk("t6_count", bus_a.fall_count_o, 0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (10) @(negedge clk);
            bus_a.pulse_num_i = 8'h01;
            bus_a.pulse_start_i = 2'b01;
            for (int n = 1; n <= 30; n++) begin
                @(negedge clk);
                if (n == 1) bus_a.pulse_start_i = '0;
                if (bus_a.pulse_done_o[0]) begin nd++; at_d = n; end
                if (bus_a.fall_o[1]) nf++;
            end
            chk("t6_new_done_n", nd, 1);
            chk("t6_new_done_at", at_d, 21);
            chk("t6_new_falls", nf, 1);
            chk("t6_new_count0", bus_a.fall_count_o[7:0], 1);
            chk("t6_new_count1", bus_a.fall_count_o[15:8], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
